mips_multicycle_ctrl: RTL and testbench

MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

---
 rtl/mips_multicycle_ctrl_if.sv | 28 ++
 rtl/mips_multicycle_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_ctrl_if
// Description : Shared-memory handshake between the multicycle MIPS control
//               unit (master) and the instruction/data memory (slave).
// Revision    : 1.0  initial release
// ============================================================================
interface mips_multicycle_ctrl_if;
    logic mem_read;     // read request for the current cycle
    logic mem_write;    // write request for the current cycle
    logic iord;         // 0 = instruction address (PC), 1 = data address
    logic mem_ready;    // 1 = the current read/write completes this cycle

    modport master (
        output mem_read,
        output mem_write,
        output iord,
        input  mem_ready
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  iord,
        output mem_ready
    );
endinterface
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_ctrl
// Description : Multicycle MIPS control FSM (lw, sw, R-type, beq, j and
//               optionally addi) with a shared-memory ready handshake, a
//               per-instruction completion pulse and a sticky illegal-opcode
//               flag. Define MIPS_CTRL_ADDI_EN to build addi support
//               (ADDIEX/ADDIWB states, opcode 001000 legal).
// Revision    : 1.0  initial release
// ============================================================================
module mips_multicycle_ctrl (
    input  wire logic               clk,
    input  wire logic               reset,      // asynchronous, active-low
    input  wire logic [5:0]         opcode,
    mips_multicycle_ctrl_if.master  mem,
    output logic                    pc_write,
    output logic                    pc_write_cond,
    output logic                    ir_write,
    output logic                    mem_to_reg,
    output logic                    reg_dst,
    output logic                    reg_write,
    output logic                    alu_src_a,
    output logic [1:0]              alu_src_b,
    output logic [1:0]              alu_op,
    output logic [1:0]              pc_source,
    output logic [3:0]              state,
    output logic                    instr_done,
    output logic                    illegal_op
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_CTRL_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
`ifdef MIPS_CTRL_ADDI_EN
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
`endif
        JUMP   = 4'd11
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   illegal_q;
    logic   set_illegal;

    // State register; reset abandons any instruction in flight and returns to FETCH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Sticky illegal-opcode flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal_q <= 1'b0;
        end else if (set_illegal) begin
            illegal_q <= 1'b1;
        end
    end

    // Next-state and Moore/ready-qualified control decode.
    always_comb begin
        state_d       = FETCH;
        set_illegal   = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        instr_done    = 1'b0;
        mem.mem_read  = 1'b0;
        mem.mem_write = 1'b0;
        mem.iord      = 1'b0;

        case (state_q)
            FETCH: begin
                mem.mem_read = 1'b1;
                alu_src_b    = 2'b01;
                // PC+4 and IR load only on the completing cycle, never during reset
                ir_write     = mem.mem_ready & reset;
                pc_write     = mem.mem_ready & reset;
                state_d      = mem.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
`ifdef MIPS_CTRL_ADDI_EN
                    OP_ADDI:      state_d = ADDIEX;
`endif
                    default: begin
                        state_d     = FETCH;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem.mem_read = 1'b1;
                mem.iord     = 1'b1;
                state_d      = mem.mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                mem.mem_write = 1'b1;
                mem.iord      = 1'b1;
                instr_done    = mem.mem_ready;
                state_d       = mem.mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_done    = 1'b1;
                state_d       = FETCH;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
`ifdef MIPS_CTRL_ADDI_EN
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = ADDIWB;
            end
            ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
`endif
            // Unused encodings recover to FETCH with all controls idle
            default: state_d = FETCH;
        endcase
    end

    assign state      = state_q;
    assign illegal_op = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_multicycle_ctrl
// Description : Table-driven self-checking bench for mips_multicycle_ctrl,
//               plus hand sequences for reset and mid-wait reset.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mips_multicycle_ctrl;

    // Control word: {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
    //                mem_to_reg, reg_dst, reg_write, alu_src_a,
    //                alu_src_b[1:0], alu_op[1:0], pc_source[1:0], instr_done}
    localparam logic [16:0] C_FETCH_WAIT = 17'b000100_0000_01_00_00_0;
    localparam logic [16:0] C_FETCH_GO   = 17'b100101_0000_01_00_00_0;
    localparam logic [16:0] C_DECODE     = 17'b000000_0000_11_00_00_0;
    localparam logic [16:0] C_MEMADR     = 17'b000000_0001_10_00_00_0;
    localparam logic [16:0] C_MEMRD      = 17'b001100_0000_00_00_00_0;
    localparam logic [16:0] C_MEMWB      = 17'b000000_1010_00_00_00_1;
    localparam logic [16:0] C_MEMWR_WAIT = 17'b001010_0000_00_00_00_0;
    localparam logic [16:0] C_MEMWR_GO   = 17'b001010_0000_00_00_00_1;
    localparam logic [16:0] C_EXEC       = 17'b000000_0001_00_10_00_0;
    localparam logic [16:0] C_ALUWB      = 17'b000000_0110_00_00_00_1;
    localparam logic [16:0] C_BRANCH     = 17'b010000_0001_00_01_01_1;
    localparam logic [16:0] C_JUMP       = 17'b100000_0000_00_00_10_1;
`ifdef MIPS_CTRL_ADDI_EN
    localparam logic [16:0] C_ADDIEX     = 17'b000000_0001_10_00_00_0;
    localparam logic [16:0] C_ADDIWB     = 17'b000000_0010_00_00_00_1;
`endif

    typedef struct {
        logic [5:0]  opcode;
        logic        mem_ready;
        logic [3:0]  exp_state;
        logic [16:0] exp_ctrl;
        logic        exp_ill;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [5:0]  opcode;
    logic        pc_write, pc_write_cond, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic        instr_done, illegal_op;

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem           (bus),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .state         (state),
        .instr_done    (instr_done),
        .illegal_op    (illegal_op)
    );

    logic [16:0] act_ctrl;
    assign act_ctrl = {pc_write, pc_write_cond, bus.iord, bus.mem_read, bus.mem_write, ir_write,
                       mem_to_reg, reg_dst, reg_write, alu_src_a,
                       alu_src_b, alu_op, pc_source, instr_done};

    int   n_total;
    int   n_pass;
    vec_t vecs[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare {state, illegal_op, control word} against a required value.
    task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got state=%0d ill=%b ctrl=%b, want state=%0d ill=%b ctrl=%b",
                     name, act[21:18], act[17], act[16:0], exp[21:18], exp[17], exp[16:0]);
        end else begin
            n_pass++;
        end
    endtask

    task automatic add(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                       input logic [16:0] ctrl, input logic ill);
        vec_t v;
        v.opcode = op; v.mem_ready = rdy; v.exp_state = st; v.exp_ctrl = ctrl; v.exp_ill = ill;
        vecs.push_back(v);
    endtask

    task automatic next_slot;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int done_cnt;
        int exp_done;
        n_total  = 0;
        n_pass   = 0;
        done_cnt = 0;

        // lw with two waiting FETCH cycles
        add(6'b100011, 1'b0, 4'd0, C_FETCH_WAIT, 1'b0);
        add(6'b100011, 1'b0, 4'd0, C_FETCH_WAIT, 1'b0);
        add(6'b100011, 1'b1, 4'd0, C_FETCH_GO,   1'b0);
        add(6'b100011, 1'b1, 4'd1, C_DECODE,     1'b0);
        add(6'b100011, 1'b1, 4'd2, C_MEMADR,     1'b0);
        add(6'b100011, 1'b1, 4'd3, C_MEMRD,      1'b0);
        add(6'b100011, 1'b1, 4'd4, C_MEMWB,      1'b0);
        // R-type
        add(6'b000000, 1'b1, 4'd0, C_FETCH_GO,   1'b0);
        add(6'b000000, 1'b1, 4'd1, C_DECODE,     1'b0);
        add(6'b000000, 1'b1, 4'd6, C_EXEC,       1'b0);
        add(6'b000000, 1'b1, 4'd7, C_ALUWB,      1'b0);
        // sw with one write wait
        add(6'b101011, 1'b1, 4'd0, C_FETCH_GO,   1'b0);
        add(6'b101011, 1'b1, 4'd1, C_DECODE,     1'b0);
        add(6'b101011, 1'b1, 4'd2, C_MEMADR,     1'b0);
        add(6'b101011, 1'b0, 4'd5, C_MEMWR_WAIT, 1'b0);
        add(6'b101011, 1'b1, 4'd5, C_MEMWR_GO,   1'b0);
        // beq then j
        add(6'b000100, 1'b1, 4'd0, C_FETCH_GO,   1'b0);
        add(6'b000100, 1'b1, 4'd1, C_DECODE,     1'b0);
        add(6'b000100, 1'b1, 4'd8, C_BRANCH,     1'b0);
        add(6'b000010, 1'b1, 4'd0, C_FETCH_GO,   1'b0);
        add(6'b000010, 1'b1, 4'd1, C_DECODE,     1'b0);
        add(6'b000010, 1'b1, 4'd11, C_JUMP,      1'b0);
        // addi
        add(6'b001000, 1'b1, 4'd0, C_FETCH_GO,   1'b0);
        add(6'b001000, 1'b1, 4'd1, C_DECODE,     1'b0);
`ifdef MIPS_CTRL_ADDI_EN
        add(6'b001000, 1'b1, 4'd9,  C_ADDIEX,    1'b0);
        add(6'b001000, 1'b1, 4'd10, C_ADDIWB,    1'b0);
        // unsupported opcode returns to FETCH and raises the flag
        add(6'b111111, 1'b1, 4'd0, C_FETCH_GO,   1'b0);
        add(6'b111111, 1'b1, 4'd1, C_DECODE,     1'b0);
        exp_done = 7;
`else
        exp_done = 6;
`endif
        // back in FETCH with the flag set; a legal beq keeps it set
        add(6'b111111, 1'b1, 4'd0, C_FETCH_GO,   1'b1);
        add(6'b111111, 1'b1, 4'd1, C_DECODE,     1'b1);
        add(6'b000100, 1'b1, 4'd0, C_FETCH_GO,   1'b1);
        add(6'b000100, 1'b1, 4'd1, C_DECODE,     1'b1);
        add(6'b000100, 1'b1, 4'd8, C_BRANCH,     1'b1);

        // Reset asserted: FETCH decode with pc_write/ir_write held low
        reset         = 1'b1;
        opcode        = 6'b000000;
        bus.mem_ready = 1'b1;
        #2 reset = 1'b0;
        #1 check("reset_async", {state, illegal_op, act_ctrl}, {4'd0, 1'b0, C_FETCH_WAIT});
        next_slot();
        next_slot();
        @(negedge clk);
        check("reset_held", {state, illegal_op, act_ctrl}, {4'd0, 1'b0, C_FETCH_WAIT});
        next_slot();
        reset = 1'b1;

        // Table: first row is the first FETCH cycle after reset release
        foreach (vecs[i]) begin
            string nm;
            opcode        = vecs[i].opcode;
            bus.mem_ready = vecs[i].mem_ready;
            @(negedge clk);
            nm = $sformatf("row%0d", i);
            check(nm, {state, illegal_op, act_ctrl},
                  {vecs[i].exp_state, vecs[i].exp_ill, vecs[i].exp_ctrl});
            if (instr_done) done_cnt++;
            next_slot();
        end
        n_total++;
        if (done_cnt != exp_done)
            $display("FAIL done_pulses: got %0d, want %0d", done_cnt, exp_done);
        else
            n_pass++;

        // sw stalled in MEMWR, then reset mid-wait abandons it
        opcode        = 6'b101011;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        check("sw_fetch", {state, illegal_op, act_ctrl}, {4'd0, 1'b1, C_FETCH_GO});
        next_slot();
        next_slot();
        next_slot();
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check("sw_wait", {state, illegal_op, act_ctrl}, {4'd5, 1'b1, C_MEMWR_WAIT});
        #2 reset = 1'b0;
        #1 check("sw_reset_async", {state, illegal_op, act_ctrl}, {4'd0, 1'b0, C_FETCH_WAIT});
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("sw_reset_cyc%0d", k), {state, illegal_op, act_ctrl},
                  {4'd0, 1'b0, C_FETCH_WAIT});
        end
        next_slot();
        reset         = 1'b1;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        check("post_reset_fetch", {state, illegal_op, act_ctrl}, {4'd0, 1'b0, C_FETCH_GO});
        next_slot();
        @(negedge clk);
        check("post_reset_decode", {state, illegal_op, act_ctrl}, {4'd1, 1'b0, C_DECODE});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
